runner_ctrl: RTL and testbench

Parametrised player-motion controller for Rail Rush: N lanes with smooth per-frame lane transitions, a jump state machine with fast-fall, and a time-limited slide with jump-cancel. It sits between the button edge-detectors and the obstacle and collision logic, and advances once per `frame_done`. It produces player position, the current lane and the clearance flags. It does no pixel rendering; the renderer consumes `player_x`/`player_y`.

---
 rtl/runner_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_runner_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/runner_ctrl.sv
// runner_ctrl: player-motion controller for Rail Rush (lane transits, jump with fast-fall, timed slide).
// Ports: clock/reset (async, active-high); frame_done tick strobe; button pulses and slide_hold/game_active levels in;
//        lane, player_x/player_y, state and in_transit/is_jumping/is_sliding/jump_clear/slide_clear out (all registered-state derived).
module runner_ctrl #(
  parameter int NUM_LANES      = 3,
  parameter int LANE0_X        = 144,
  parameter int LANE_PITCH     = 256,
  parameter int LANE_STEP      = 64,
  parameter int FEET_Y         = 480,
  parameter int JUMP_UP_FRAMES = 12,
  parameter int JUMP_STEP      = 6,
  parameter int CLEAR_H        = 35,
  parameter int SLIDE_MAX      = 30
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         frame_done,
  input  logic                         move_left_pulse,
  input  logic                         move_right_pulse,
  input  logic                         jump_pulse,
  input  logic                         slide_hold,
  input  logic                         game_active,
  output logic [$clog2(NUM_LANES)-1:0] lane,
  output logic [9:0]                   player_x,
  output logic [9:0]                   player_y,
  output logic [1:0]                   state,
  output logic                         in_transit,
  output logic                         is_jumping,
  output logic                         is_sliding,
  output logic                         jump_clear,
  output logic                         slide_clear
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int CW = $clog2(JUMP_UP_FRAMES + 1);
  localparam int SW = $clog2(SLIDE_MAX + 1);

  localparam logic [LW-1:0] RESET_LANE = LW'((NUM_LANES - 1) / 2);
  localparam logic [LW-1:0] LAST_LANE  = LW'(NUM_LANES - 1);
  localparam logic [9:0]    RESET_X    = 10'(LANE0_X + ((NUM_LANES - 1) / 2) * LANE_PITCH);
  localparam logic [9:0]    STEP_X     = 10'(LANE_STEP);
  localparam logic [9:0]    JSTEP      = 10'(JUMP_STEP);
  localparam logic [9:0]    JSTEP2     = 10'(2 * JUMP_STEP);

  generate
    if (NUM_LANES < 2 || NUM_LANES > 4) begin : g_bad_lanes
      $error("runner_ctrl: NUM_LANES must be 2..4");
    end
    if (JUMP_UP_FRAMES * JUMP_STEP >= FEET_Y) begin : g_bad_jump
      $error("runner_ctrl: jump apex would leave the screen");
    end
    if (LANE0_X + (NUM_LANES - 1) * LANE_PITCH >= 1024) begin : g_bad_x
      $error("runner_ctrl: rightmost lane x does not fit in 10 bits");
    end
    if (LANE_PITCH % LANE_STEP != 0) begin : g_bad_step
      $error("runner_ctrl: LANE_PITCH must be a multiple of LANE_STEP");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_SLIDE  = 2'd3
  } state_e;

  function automatic logic [9:0] lane_x(input logic [LW-1:0] l);
    return 10'(LANE0_X) + 10'(LANE_PITCH) * 10'(l);
  endfunction

  state_e        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          lock_q, lock_d;
  logic          left_q, left_d, right_q, right_d, jump_q, jump_d;

  logic          tick;
  logic          transit;
  logic [9:0]    new_tgt;
  logic [9:0]    fall_dec;

  assign tick     = frame_done & game_active;
  assign transit  = (x_q != lane_x(lane_q));
  assign fall_dec = slide_hold ? JSTEP2 : JSTEP;

  // Button latches: a pulse wins over the clearing frame_done so it is seen next frame.
  // They clear on every frame_done, frozen or not, so presses never queue up across a pause.
  always_comb begin
    left_d  = move_left_pulse  | (left_q  & ~frame_done);
    right_d = move_right_pulse | (right_q & ~frame_done);
    jump_d  = jump_pulse       | (jump_q  & ~frame_done);
  end

  // Lane select and horizontal motion. The step is taken toward the new target on the
  // accepting tick itself, so a one-lane move finishes after LANE_PITCH/LANE_STEP ticks.
  always_comb begin
    lane_d = lane_q;
    x_d    = x_q;
    if (tick && !transit) begin
      if (left_q) begin
        if (lane_q != '0) lane_d = lane_q - LW'(1);
      end else if (right_q && lane_q != LAST_LANE) begin
        lane_d = lane_q + LW'(1);
      end
    end
    new_tgt = lane_x(lane_d);
    if (tick) begin
      if (x_q < new_tgt)      x_d = x_q + STEP_X;
      else if (x_q > new_tgt) x_d = x_q - STEP_X;
    end
  end

  // Jump/slide state machine.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    lock_d  = lock_q;
    if (tick) begin
      if (!slide_hold) lock_d = 1'b0;
      case (state_q)
        ST_GROUND: begin
          if (jump_q) begin
            state_d = ST_RISE;
            cnt_d   = CW'(JUMP_UP_FRAMES);
            off_d   = '0;
          end else if (slide_hold && !lock_q) begin
            state_d = ST_SLIDE;
            scnt_d  = SW'(1);
          end
        end
        ST_RISE: begin
          if (slide_hold) begin
            // Fast-fall: abandon the rise without adding this tick's step.
            state_d = ST_FALL;
            cnt_d   = '0;
          end else begin
            off_d = off_q + JSTEP;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_FALL;
          end
        end
        ST_FALL: begin
          if (off_q <= fall_dec) begin
            off_d   = '0;
            state_d = ST_GROUND;
          end else begin
            off_d = off_q - fall_dec;
          end
        end
        ST_SLIDE: begin
          if (jump_q) begin
            state_d = ST_RISE;
            cnt_d   = CW'(JUMP_UP_FRAMES);
            off_d   = '0;
            scnt_d  = '0;
          end else if (!slide_hold) begin
            state_d = ST_GROUND;
            scnt_d  = '0;
          end else if (scnt_q == SW'(SLIDE_MAX)) begin
            // Slide timed out: stay down until the button is released once.
            state_d = ST_GROUND;
            scnt_d  = '0;
            lock_d  = 1'b1;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        default: state_d = ST_GROUND;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_GROUND;
      lane_q  <= RESET_LANE;
      x_q     <= RESET_X;
      off_q   <= '0;
      cnt_q   <= '0;
      scnt_q  <= '0;
      lock_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      x_q     <= x_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      lock_q  <= lock_d;
      left_q  <= left_d;
      right_q <= right_d;
      jump_q  <= jump_d;
    end
  end

  assign lane        = lane_q;
  assign player_x    = x_q;
  assign player_y    = 10'(FEET_Y) - off_q;
  assign state       = state_q;
  assign in_transit  = transit;
  assign is_jumping  = (state_q == ST_RISE) || (state_q == ST_FALL);
  assign is_sliding  = (state_q == ST_SLIDE);
  assign jump_clear  = (off_q >= 10'(CLEAR_H));
  assign slide_clear = is_sliding;

endmodule

// File: tb/tb_runner_ctrl.sv
module tb_runner_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_done = 1'b0;
  logic       ml = 1'b0, mr = 1'b0, jp = 1'b0;
  logic       sh = 1'b0;
  logic       ga = 1'b1;
  logic [1:0] lane_o;
  logic [9:0] px, py;
  logic [1:0] st;
  logic       it, ij, isl, jc, sc;

  always #5 clock = ~clock;

  runner_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .frame_done       (frame_done),
    .move_left_pulse  (ml),
    .move_right_pulse (mr),
    .jump_pulse       (jp),
    .slide_hold       (sh),
    .game_active      (ga),
    .lane             (lane_o),
    .player_x         (px),
    .player_y         (py),
    .state            (st),
    .in_transit       (it),
    .is_jumping       (ij),
    .is_sliding       (isl),
    .jump_clear       (jc),
    .slide_clear      (sc)
  );

  int checks = 0;
  int errors = 0;
  bit run = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: motion described as plain integers (pixel x, height above feet,
  // phase 0..3, frame counters), stepped once per cycle with the inputs just driven.
  int m_lane, m_x, m_off, m_st, m_up, m_slide, m_lock, m_l, m_r, m_j;

  function automatic int lx(input int l);
    return 144 + l * 256;
  endfunction

  task automatic model_reset();
    m_lane = 1; m_x = 400; m_off = 0; m_st = 0; m_up = 0; m_slide = 0;
    m_lock = 0; m_l = 0; m_r = 0; m_j = 0;
  endtask

  task automatic model_step();
    int pl, pr, pj;
    pl = m_l; pr = m_r; pj = m_j;
    if (frame_done && ga) begin
      if (m_x == lx(m_lane)) begin
        if (pl) m_lane = (m_lane > 0) ? m_lane - 1 : m_lane;
        else if (pr && m_lane < 2) m_lane = m_lane + 1;
      end
      if (m_x < lx(m_lane)) m_x += 64;
      else if (m_x > lx(m_lane)) m_x -= 64;
      case (m_st)
        0: if (pj) begin m_st = 1; m_up = 12; m_off = 0; end
           else if (sh && !m_lock) begin m_st = 3; m_slide = 1; end
        1: if (sh) m_st = 2;
           else begin
             m_off += 6; m_up--;
             if (m_up == 0) m_st = 2;
           end
        2: begin
             m_off -= sh ? 12 : 6;
             if (m_off <= 0) begin m_off = 0; m_st = 0; end
           end
        default: if (pj) begin m_st = 1; m_up = 12; m_off = 0; m_slide = 0; end
           else if (!sh) begin m_st = 0; m_slide = 0; end
           else if (m_slide == 30) begin m_st = 0; m_slide = 0; m_lock = 1; end
           else m_slide++;
      endcase
      if (!sh) m_lock = 0;
    end
    m_l = (ml || (m_l && !frame_done)) ? 1 : 0;
    m_r = (mr || (m_r && !frame_done)) ? 1 : 0;
    m_j = (jp || (m_j && !frame_done)) ? 1 : 0;
  endtask

  // Compare every cycle, just after the active edge has settled.
  always @(posedge clock) begin
    #1;
    if (run && !reset) begin
      chk("lane", lane_o, m_lane);
      chk("player_x", px, m_x);
      chk("player_y", py, 480 - m_off);
      chk("state", st, m_st);
      chk("in_transit", it, (m_x != lx(m_lane)) ? 1 : 0);
      chk("is_jumping", ij, (m_st == 1 || m_st == 2) ? 1 : 0);
      chk("is_sliding", isl, (m_st == 3) ? 1 : 0);
      chk("jump_clear", jc, (m_off >= 35) ? 1 : 0);
      chk("slide_clear", sc, (m_st == 3) ? 1 : 0);
    end
  end

  // One clock: drive inputs at the falling edge, advance the model, release pulses.
  task automatic cyc(input logic fd, input logic l, input logic r, input logic j);
    frame_done = fd; ml = l; mr = r; jp = j;
    model_step();
    @(negedge clock);
    frame_done = 1'b0; ml = 1'b0; mr = 1'b0; jp = 1'b0;
  endtask

  task automatic tick(input logic l, input logic r, input logic j);
    cyc(1'b1, l, r, j);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst lane", lane_o, 1);
    chk("rst x", px, 400);
    chk("rst y", py, 480);
    chk("rst state", st, 0);
    chk("rst transit", it, 0);
    reset = 1'b0;
    run = 1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Left move: lane changes at once, x walks 336, 272, 208, 144.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("left lane", lane_o, 0);
    chk("left x1", px, 336);
    chk("left transit1", it, 1);
    tick(1'b0, 1'b1, 1'b0);            // right press during transit
    chk("left x2", px, 272);
    ticks(1);
    chk("left x3", px, 208);
    ticks(1);
    chk("left x4", px, 144);
    chk("left transit4", it, 0);
    ticks(1);
    chk("right discarded", lane_o, 0);
    // Left at lane 0 is ignored.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("edge lane", lane_o, 0);
    chk("edge x", px, 144);

    // Jump pulse coincident with frame_done: taken on the following tick.
    tick(1'b0, 1'b0, 1'b1);
    chk("coinc state", st, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("accept state", st, 1);
    chk("accept y", py, 480);
    ticks(5);
    chk("rise5 y", py, 450);
    chk("rise5 clear", jc, 0);
    ticks(1);
    chk("rise6 y", py, 444);
    chk("rise6 clear", jc, 1);
    ticks(6);
    chk("peak y", py, 408);
    chk("peak state", st, 2);
    ticks(12);
    chk("land y", py, 480);
    chk("land state", st, 0);

    // Fast-fall from rise tick 5.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    ticks(5);
    chk("ff start y", py, 450);
    sh = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("ff state", st, 2);
    chk("ff y0", py, 450);
    ticks(1);
    chk("ff y1", py, 462);
    ticks(1);
    chk("ff y2", py, 474);
    ticks(1);
    chk("ff y3", py, 480);
    chk("ff ground", st, 0);
    sh = 1'b0;
    ticks(1);

    // Slide held 40 ticks: 30 ticks of SLIDE then locked out on the ground.
    sh = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("slide enter", st, 3);
    ticks(29);
    chk("slide 30", st, 3);
    ticks(1);
    chk("slide timeout", st, 0);
    ticks(9);
    chk("slide locked", st, 0);
    sh = 1'b0;
    ticks(1);
    sh = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("slide again", st, 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    sh = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    chk("slide cancel", st, 1);
    ticks(24);
    chk("cancel land", st, 0);

    // Reset in the middle of a rise and a transit.
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk("mid lane", lane_o, 1);
    chk("mid x", px, 208);
    ticks(2);
    chk("mid y", py, 468);
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid-rst lane", lane_o, 1);
    chk("mid-rst x", px, 400);
    chk("mid-rst y", py, 480);
    chk("mid-rst state", st, 0);
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Freeze with game_active low mid-transit and mid-rise.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("pre-freeze x", px, 272);
    chk("pre-freeze y", py, 474);
    ga = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    ticks(5);
    chk("frz lane", lane_o, 0);
    chk("frz x", px, 272);
    chk("frz y", py, 474);
    chk("frz state", st, 1);
    ga = 1'b1;
    ticks(24);
    chk("thaw state", st, 0);
    chk("thaw x", px, 144);
    // Presses made while frozen are dropped at the frozen frame.
    ga = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    ticks(1);
    ga = 1'b1;
    ticks(2);
    chk("latch cleared lane", lane_o, 0);
    chk("latch cleared state", st, 0);

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
